mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between an instruction-fetch requester (IF) and a
// load/store requester (LS). At most one transaction is in flight. Ties are
// broken round-robin: the requester that did not win the previous grant wins.
// A WAIT-state watchdog aborts a transaction that never receives mem_rvalid
// and returns an error response instead.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   if_req/if_addr  : fetch read request (held until granted)
//   if_gnt          : one-cycle combinational grant pulse to fetch
//   if_rvalid/if_rdata/if_err : fetch response (one-cycle pulse)
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wmask : load/store request
//   ls_gnt          : one-cycle combinational grant pulse to load/store
//   ls_rvalid/ls_rdata/ls_err : load/store response (one-cycle pulse)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask : shared memory request
//   mem_ready       : memory accepts the request this cycle
//   mem_rvalid/mem_rdata : memory response (writes also return one)
// ----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   output logic            if_err,

   input  logic            ls_req,
   input  logic            ls_we,
   input  logic [AW-1:0]   ls_addr,
   input  logic [DW-1:0]   ls_wdata,
   input  logic [DW/8-1:0] ls_wmask,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [DW-1:0]   ls_rdata,
   output logic            ls_err,

   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wmask,
   input  logic            mem_ready,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int MW = DW / 8;

   // Counter value seen in the last permitted WAIT cycle; the counter starts
   // at 0 on WAIT entry, so the TIMEOUT-th empty cycle sees TIMEOUT-1.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q;
   logic            last_owner_q;
   logic [7:0]      cnt_q;

   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [MW-1:0]   wmask_q;

   logic            if_rvalid_q, if_err_q;
   logic            ls_rvalid_q, ls_err_q;
   logic [DW-1:0]   if_rdata_q, ls_rdata_q;

   logic            grant_if, grant_ls, grant_any;
   logic            timeout_hit;

   // Arbitration: only in IDLE; a tie goes to whoever did not win last time.
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (state_q == S_IDLE) begin
         if (if_req && ls_req) begin
            if (last_owner_q == OWN_LS) grant_if = 1'b1;
            else                        grant_ls = 1'b1;
         end else begin
            grant_if = if_req;
            grant_ls = ls_req;
         end
      end
   end

   assign grant_any   = grant_if | grant_ls;
   assign timeout_hit = (cnt_q == TO_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_any)                  state_d = S_REQ;
         S_REQ:   if (mem_ready)                  state_d = S_WAIT;
         S_WAIT:  if (mem_rvalid || timeout_hit)  state_d = S_IDLE;
         default:                                 state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      if_gnt  = grant_if;
      ls_gnt  = grant_ls;
      mem_req = (state_q == S_REQ);
   end

   // Latched request fields drive the memory port directly; they are zero
   // out of reset and only change at a grant edge, so they stay stable for
   // the whole REQ phase.
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;

   assign if_rvalid = if_rvalid_q;
   assign if_err    = if_err_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rvalid = ls_rvalid_q;
   assign ls_err    = ls_err_q;
   assign ls_rdata  = ls_rdata_q;

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_LS;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         if_rvalid_q  <= 1'b0;
         if_err_q     <= 1'b0;
         if_rdata_q   <= '0;
         ls_rvalid_q  <= 1'b0;
         ls_err_q     <= 1'b0;
         ls_rdata_q   <= '0;
      end else begin
         // Response flags are single-cycle pulses.
         if_rvalid_q <= 1'b0;
         if_err_q    <= 1'b0;
         ls_rvalid_q <= 1'b0;
         ls_err_q    <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (grant_any) begin
                  owner_q      <= grant_ls ? OWN_LS : OWN_IF;
                  last_owner_q <= grant_ls ? OWN_LS : OWN_IF;
                  if (grant_ls) begin
                     we_q    <= ls_we;
                     addr_q  <= ls_addr;
                     wdata_q <= ls_wdata;
                     wmask_q <= ls_wmask;
                  end else begin
                     // Fetches are pure reads.
                     we_q    <= 1'b0;
                     addr_q  <= if_addr;
                     wdata_q <= '0;
                     wmask_q <= '0;
                  end
               end
            end

            S_REQ: begin
               if (mem_ready) cnt_q <= '0;
            end

            S_WAIT: begin
               if (mem_rvalid) begin
                  if (owner_q == OWN_IF) begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= mem_rdata;
                  end else begin
                     ls_rvalid_q <= 1'b1;
                     ls_rdata_q  <= mem_rdata;
                  end
               end else if (timeout_hit) begin
                  // Abort: error response with zero data.
                  if (owner_q == OWN_IF) begin
                     if_rvalid_q <= 1'b1;
                     if_err_q    <= 1'b1;
                     if_rdata_q  <= '0;
                  end else begin
                     ls_rvalid_q <= 1'b1;
                     ls_err_q    <= 1'b1;
                     ls_rdata_q  <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            default: ;
         endcase
      end
   end

endmodule
